// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block path: widths, initial hash value
// and the message-feeder state encodings.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_W     = 512;
    localparam int DIGEST_W    = 256;

    localparam logic [DIGEST_W-1:0] H0 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_PAD     = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    // A final word can carry at most four bytes; larger counts saturate.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
        return (b > 3'd4) ? 3'd4 : b;
    endfunction

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational padding for the final message block: keeps message bytes
// below the pad position, inserts 0x80 and the length, and describes any spill block.
module sha256_pad_block
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0] buf_i,
    input  logic [3:0]         last_idx_i,
    input  logic [2:0]         last_bytes_i,
    input  logic [63:0]        bit_len_i,
    output logic [BLOCK_W-1:0] pad_block_o,
    output logic [BLOCK_W-1:0] extra_block_o,
    output logic               extra_o,
    output logic               final_o
);

    logic [6:0] pad_pos;

    assign pad_pos = {1'b0, last_idx_i, 2'b00} + {4'b0000, last_bytes_i};
    assign extra_o = (pad_pos > 7'd55);
    assign final_o = !extra_o;

    // NOTE: every output gets a default before any conditional override, so no latch can be inferred.
    always_comb begin
        pad_block_o = '0;
        for (int b = 0; b < 64; b++) begin
            if (7'(b) < pad_pos) begin
                pad_block_o[BLOCK_W-1-8*b -: 8] = buf_i[BLOCK_W-1-8*b -: 8];
            end else if (7'(b) == pad_pos) begin
                pad_block_o[BLOCK_W-1-8*b -: 8] = 8'h80;
            end
        end
        if (pad_pos <= 7'd55) begin
            pad_block_o[63:0] = bit_len_i;
        end

        // Spill block: zeros plus length, with the 0x80 marker only if the message filled the block exactly.
        extra_block_o                        = '0;
        extra_block_o[63:0]                  = bit_len_i;
        extra_block_o[BLOCK_W-1 -: 8]        = (pad_pos == 7'd64) ? 8'h80 : 8'h00;
    end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Streams a word-oriented message into 512-bit SHA-256 blocks, applies final
// padding, chains intermediate hashes and presents the final digest.
module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
    input  logic [2:0]          s_bytes,
    output logic                blk_start,
    output logic [BLOCK_W-1:0]  blk_data,
    output logic                blk_init_hash,
    output logic [DIGEST_W-1:0] blk_hash_in,
    input  logic                blk_busy,
    input  logic                blk_done,
    input  logic [DIGEST_W-1:0] blk_hash_out,
    output logic                busy,
    output logic                digest_valid,
    output logic [DIGEST_W-1:0] digest
);

    logic [2:0]                            state_q, state_d;
    logic [3:0]                            idx_q, idx_d;
    logic [3:0]                            last_idx_q, last_idx_d;
    logic [2:0]                            last_bytes_q, last_bytes_d;
    logic [LEN_W-1:0]                      bit_cnt_q, bit_cnt_d;
    logic                                  first_q, first_d;
    logic                                  extra_q, extra_d;
    logic                                  final_q, final_d;
    logic                                  busy_q, busy_d;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]    buf_q, buf_d;
    logic [BLOCK_W-1:0]                    blk_data_q, blk_data_d;
    logic [DIGEST_W-1:0]                   blk_hash_in_q, blk_hash_in_d;
    logic [DIGEST_W-1:0]                   digest_q, digest_d;

    logic [2:0]                            word_bytes;
    logic [63:0]                           bit_len64;
    logic [BLOCK_W-1:0]                    pad_block;
    logic [BLOCK_W-1:0]                    extra_block;
    logic                                  pad_extra;
    logic                                  pad_final;
    logic                                  unused_core_busy;

    // The core's busy flag is informational; the done pulse alone closes a block.
    assign unused_core_busy = blk_busy;

    assign word_bytes = s_last ? clamp_bytes(s_bytes) : 3'd4;
    assign bit_len64  = 64'(bit_cnt_q);

    sha256_pad_block u_pad (
        .buf_i         (buf_q),
        .last_idx_i    (last_idx_q),
        .last_bytes_i  (last_bytes_q),
        .bit_len_i     (bit_len64),
        .pad_block_o   (pad_block),
        .extra_block_o (extra_block),
        .extra_o       (pad_extra),
        .final_o       (pad_final)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_idx_d    = last_idx_q;
        last_bytes_d  = last_bytes_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        extra_d       = extra_q;
        final_d       = final_q;
        busy_d        = busy_q;
        buf_d         = buf_q;
        blk_data_d    = blk_data_q;
        blk_hash_in_d = blk_hash_in_q;
        digest_d      = digest_q;

        case (state_q)
            ST_COLLECT: begin
                if (s_valid) begin
                    buf_d[4'd15 - idx_q] = s_data;
                    idx_d                = idx_q + 4'd1;
                    bit_cnt_d            = bit_cnt_q + LEN_W'({word_bytes, 3'b000});
                    busy_d               = 1'b1;
                    if (s_last) begin
                        last_idx_d   = idx_q;
                        last_bytes_d = word_bytes;
                        state_d      = ST_PAD;
                    end else if (idx_q == 4'd15) begin
                        blk_data_d = buf_d;
                        final_d    = 1'b0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                blk_data_d = pad_block;
                extra_d    = pad_extra;
                final_d    = pad_final;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (blk_done) begin
                    blk_hash_in_d = blk_hash_out;
                    first_d       = 1'b0;
                    // Pad inputs are untouched while a block is out, so the spill block is still valid here.
                    if (extra_q) begin
                        blk_data_d = extra_block;
                        extra_d    = 1'b0;
                        final_d    = 1'b1;
                        state_d    = ST_ISSUE;
                    end else if (final_q) begin
                        digest_d = blk_hash_out;
                        busy_d   = 1'b0;
                        state_d  = ST_FINISH;
                    end else begin
                        idx_d   = 4'd0;
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_FINISH: begin
                idx_d        = 4'd0;
                last_idx_d   = 4'd0;
                last_bytes_d = 3'd0;
                bit_cnt_d    = '0;
                first_d      = 1'b1;
                extra_d      = 1'b0;
                final_d      = 1'b0;
                state_d      = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            idx_q         <= 4'd0;
            last_idx_q    <= 4'd0;
            last_bytes_q  <= 3'd0;
            bit_cnt_q     <= '0;
            first_q       <= 1'b1;
            extra_q       <= 1'b0;
            final_q       <= 1'b0;
            busy_q        <= 1'b0;
            blk_data_q    <= '0;
            blk_hash_in_q <= '0;
            digest_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            last_idx_q    <= last_idx_d;
            last_bytes_q  <= last_bytes_d;
            bit_cnt_q     <= bit_cnt_d;
            first_q       <= first_d;
            extra_q       <= extra_d;
            final_q       <= final_d;
            busy_q        <= busy_d;
            blk_data_q    <= blk_data_d;
            blk_hash_in_q <= blk_hash_in_d;
            digest_q      <= digest_d;
        end
    end

    // NOTE: the word buffer has no reset; padding masks every byte at or beyond the pad position.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign s_ready       = (state_q == ST_COLLECT);
    assign blk_start     = (state_q == ST_ISSUE);
    assign blk_data      = blk_data_q;
    assign blk_init_hash = first_q;
    assign blk_hash_in   = blk_hash_in_q;
    assign busy          = busy_q;
    assign digest_valid  = (state_q == ST_FINISH);
    assign digest        = digest_q;

endmodule
